// File: rtl/div_iter.sv
// Iterative restoring divider, signed or unsigned, retiring BITS_PER_CYCLE
// quotient bits per cycle.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   start_i         request; held high until the result has been taken
//   annul_i         abort an operation that is in flight
//   signed_div_i    1 = two's-complement divide, 0 = unsigned
//   opdata1_i/2_i   dividend / divisor, sampled only on the accept edge
//   result_o        {remainder, quotient}, non-zero only while ready_o=1
//   ready_o         result valid
//   busy_o          operation in progress
//   div_by_zero_o   divisor was zero (qualified by ready_o)
module div_iter #(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 annul_i,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 busy_o,
   output logic                 div_by_zero_o
);

   localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
   localparam int unsigned CNT_W = $clog2(N) + 1;
   localparam int unsigned REM_W = 2 * WIDTH + 1;

   typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_t;

   state_t               state, state_nxt;
   logic [REM_W-1:0]     rem, rem_nxt, rem_step;
   logic [WIDTH-1:0]     divisor, divisor_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic                 neg_q, neg_q_nxt, neg_r, neg_r_nxt;
   logic [2*WIDTH-1:0]   result_nxt;
   logic                 ready_nxt, busy_nxt, dbz_nxt;
   logic [WIDTH-1:0]     mag1, mag2, q_fin, r_fin;

   // Operand magnitudes; negating MIN_INT yields 2^(WIDTH-1), which is the correct magnitude
   always_comb begin
      mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
      mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
   end

   // BITS_PER_CYCLE restoring shift-subtract steps on the upper WIDTH+1 bits
   always_comb begin
      rem_step = rem;
      for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
         rem_step = rem_step << 1;
         if (rem_step[REM_W-1:WIDTH] >= {1'b0, divisor}) begin
            rem_step[REM_W-1:WIDTH] = rem_step[REM_W-1:WIDTH] - {1'b0, divisor};
            rem_step[0]             = 1'b1;
         end
      end
   end

   // Sign fix-up of the final step: quotient by sign mismatch, remainder follows dividend
   always_comb begin
      q_fin = rem_step[WIDTH-1:0];
      r_fin = rem_step[2*WIDTH-1:WIDTH];
      if (neg_q) q_fin = ~q_fin + WIDTH'(1);
      if (neg_r) r_fin = ~r_fin + WIDTH'(1);
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt   = state;
      rem_nxt     = rem;
      divisor_nxt = divisor;
      cnt_nxt     = cnt;
      neg_q_nxt   = neg_q;
      neg_r_nxt   = neg_r;
      result_nxt  = '0;
      dbz_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (start_i && !annul_i) begin
               rem_nxt     = {{(WIDTH+1){1'b0}}, mag1};
               divisor_nxt = mag2;
               cnt_nxt     = '0;
               neg_q_nxt   = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
               neg_r_nxt   = signed_div_i && opdata1_i[WIDTH-1];
               state_nxt   = (opdata2_i == '0) ? BYZERO : RUN;
            end
         end
         BYZERO: begin
            if (annul_i) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = DONE;
               dbz_nxt   = 1'b1;
            end
         end
         RUN: begin
            if (annul_i) begin
               state_nxt = IDLE;
            end else begin
               rem_nxt = rem_step;
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt == CNT_W'(N - 1)) begin
                  state_nxt  = DONE;
                  result_nxt = {r_fin, q_fin};
               end
            end
         end
         DONE: begin
            if (start_i) begin
               result_nxt = result_o;
               dbz_nxt    = div_by_zero_o;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      ready_nxt = (state_nxt == DONE);
      busy_nxt  = (state_nxt == BYZERO) || (state_nxt == RUN);
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         rem           <= '0;
         divisor       <= '0;
         cnt           <= '0;
         neg_q         <= 1'b0;
         neg_r         <= 1'b0;
         result_o      <= '0;
         ready_o       <= 1'b0;
         busy_o        <= 1'b0;
         div_by_zero_o <= 1'b0;
      end else begin
         state         <= state_nxt;
         rem           <= rem_nxt;
         divisor       <= divisor_nxt;
         cnt           <= cnt_nxt;
         neg_q         <= neg_q_nxt;
         neg_r         <= neg_r_nxt;
         result_o      <= result_nxt;
         ready_o       <= ready_nxt;
         busy_o        <= busy_nxt;
         div_by_zero_o <= dbz_nxt;
      end
   end

endmodule
